// File: rtl/mvu_pkg.sv
// Shared MVU types: weight modes, pipeline sideband and the per-lane product.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mvu_pkg;

  // How a lane's 1-bit weight maps onto its data value.
  typedef enum logic [1:0] {
    MODE_PM1 = 2'b00,  // W ? -D : +D
    MODE_P1  = 2'b01,  // W ? +D : 0
    MODE_M1  = 2'b10,  // W ? -D : 0
    MODE_OFF = 2'b11   // 0
  } wmode_e;

  // Per-beat control that travels with the data down the tree.
  typedef struct packed {
    logic vld;
    logic first;
    logic shl;
    logic neg;
    logic last;
  } sb_t;

  // Working width of lane_prod; callers sign-extend in and truncate out.
  localparam int PW = 32;

  function automatic logic signed [PW-1:0] lane_prod(input logic w,
                                                     input logic signed [PW-1:0] d,
                                                     input wmode_e m);
    case (m)
      MODE_PM1: return w ? -d : d;
      MODE_P1:  return w ? d : '0;
      MODE_M1:  return w ? -d : '0;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/dotp_tree_pipe.sv
// Lane products plus registered pairwise adder tree; sideband delayed in lockstep.
// Latency: 1 (product reg) + ceil(clog2(N)/PIPE_LV) cycles.
// Backpressure: every register holds while en is low.
// Ports: clk, rst_n; en (global advance); w/d/mode operands; sb_in sideband;
//        dot (signed, DW+1+clog2(N) bits) and sb_out aligned with it.
module dotp_tree_pipe
  import mvu_pkg::*;
#(
  parameter int N       = 64,
  parameter int DW      = 2,
  parameter int PIPE_LV = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [N-1:0]                w,
  input  logic [DW*N-1:0]             d,
  input  logic [1:0]                  mode,
  input  sb_t                         sb_in,
  output logic signed [DW+$clog2(N):0] dot,
  output sb_t                         sb_out
);

  localparam int L  = $clog2(N);
  localparam int SW = DW + 1 + L;
  localparam int NP = 1 << L;

  // Lanes padded to a power of two with zero data; padded lanes contribute 0
  // in every mode. Pairing (2j, 2j+1) per level makes the top split exactly
  // lanes [0, NP/2) versus [NP/2, N).
  logic [NP-1:0]    wp;
  logic [DW*NP-1:0] dp;
  assign wp = NP'(w);
  assign dp = (DW*NP)'(d);

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int CNT = NP >> k;
    // Level 0 is the product register; afterwards a register every PIPE_LV
    // levels and always at the root so the accumulator sees a registered dot.
    localparam bit REG = (k == 0) || ((k % PIPE_LV) == 0) || (k == L);

    logic signed [SW-1:0] v [CNT];
    sb_t                  sb;

    if (k == 0) begin : g_prod
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < CNT; j++) v[j] <= '0;
          sb <= '0;
        end else if (en) begin
          for (int j = 0; j < CNT; j++)
            v[j] <= SW'(lane_prod(wp[j], PW'(signed'(dp[DW*j +: DW])), wmode_e'(mode)));
          sb <= sb_in;
        end
      end
    end else begin : g_add
      logic signed [SW-1:0] s [CNT];

      always_comb begin
        for (int j = 0; j < CNT; j++)
          s[j] = g_lvl[k-1].v[2*j] + g_lvl[k-1].v[2*j+1];
      end

      if (REG) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < CNT; j++) v[j] <= '0;
            sb <= '0;
          end else if (en) begin
            for (int j = 0; j < CNT; j++) v[j] <= s[j];
            sb <= g_lvl[k-1].sb;
          end
        end
      end else begin : g_comb
        always_comb begin
          for (int j = 0; j < CNT; j++) v[j] = s[j];
          sb = g_lvl[k-1].sb;
        end
      end
    end
  end

  assign dot    = g_lvl[L].v[0];
  assign sb_out = g_lvl[L].sb;

endmodule

// File: rtl/dotp_acc_pipe.sv
// Pipelined binary-weight dot product folded into a bit-serial accumulator.
// Latency: 2 + ceil(clog2(N)/PIPE_LV) cycles from last-beat acceptance to out_valid.
// Backpressure: in_ready = !(out_valid & !out_ready); whole pipe freezes while low.
// Ports: clk, rst_n; in_valid/in_ready with in_w, in_d, in_mode, in_first,
//        in_shl, in_neg, in_last; out_valid/out_ready with out_data (signed).
// Build option DOTP_ACC_SAT_EN: saturating accumulator plus sticky out_sat port.
module dotp_acc_pipe
  import mvu_pkg::*;
#(
  parameter int N       = 64,
  parameter int DW      = 2,
  parameter int ACC_W   = 32,
  parameter int PIPE_LV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_w,
  input  logic [DW*N-1:0]         in_d,
  input  logic [1:0]              in_mode,
  input  logic                    in_first,
  input  logic                    in_shl,
  input  logic                    in_neg,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
`ifdef DOTP_ACC_SAT_EN
  ,
  output logic                    out_sat
`endif
);

  localparam int SW = DW + 1 + $clog2(N);

  logic                    en;
  sb_t                     sb_in;
  sb_t                     tsb;
  logic signed [SW-1:0]    dot;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;

  // A held, unconsumed result is the only stall source.
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;

  assign sb_in = '{vld: in_valid, first: in_first, shl: in_shl, neg: in_neg, last: in_last};

  dotp_tree_pipe #(
    .N       (N),
    .DW      (DW),
    .PIPE_LV (PIPE_LV)
  ) u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .w      (in_w),
    .d      (in_d),
    .mode   (in_mode),
    .sb_in  (sb_in),
    .dot    (dot),
    .sb_out (tsb)
  );

`ifdef DOTP_ACC_SAT_EN
  // Two guard bits above the wider of acc/dot so shift and add never wrap
  // before clipping.
  localparam int EW = ((ACC_W > SW) ? ACC_W : SW) + 2;
  localparam logic signed [EW-1:0] MAXV = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] clip(input logic signed [EW-1:0] x);
    if (x > MAXV)      return MAXV[ACC_W-1:0];
    else if (x < MINV) return MINV[ACC_W-1:0];
    else               return x[ACC_W-1:0];
  endfunction

  logic signed [EW-1:0]    dot_x, term_x, base_x, sum_x;
  logic signed [ACC_W-1:0] base_s;
  logic                    ovf;
  logic                    sat_run;
  logic                    sat_nxt;

  // Shift and add clip separately, so an overflowing shift is flagged even
  // if the following add would have pulled the value back into range.
  always_comb begin
    dot_x  = EW'(dot);
    base_x = '0;
    if (!tsb.first) base_x = tsb.shl ? (EW'(acc) <<< 1) : EW'(acc);
    base_s  = clip(base_x);
    term_x  = tsb.neg ? -dot_x : dot_x;
    sum_x   = EW'(base_s) + term_x;
    acc_nxt = clip(sum_x);
    ovf     = (EW'(base_s) != base_x) || (EW'(acc_nxt) != sum_x);
    sat_nxt = (tsb.first ? 1'b0 : sat_run) | ovf;
  end
`else
  logic signed [ACC_W-1:0] dot_a, term_a, base_a;

  always_comb begin
    dot_a  = ACC_W'(dot);
    base_a = '0;
    if (!tsb.first) base_a = tsb.shl ? (acc <<< 1) : acc;
    term_a  = tsb.neg ? -dot_a : dot_a;
    acc_nxt = base_a + term_a;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef DOTP_ACC_SAT_EN
      sat_run   <= 1'b0;
      out_sat   <= 1'b0;
`endif
    end else if (en) begin
      if (tsb.vld) begin
        acc <= acc_nxt;
`ifdef DOTP_ACC_SAT_EN
        sat_run <= sat_nxt;
`endif
      end
      // en high means out_valid is low or being consumed this cycle.
      if (tsb.vld && tsb.last) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
`ifdef DOTP_ACC_SAT_EN
        out_sat   <= sat_nxt;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
